// File: rtl/serial_subtractor_8bit_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Latency: none (wiring only).
// Backpressure: none; start is a request, busy/done report progress.
// Ports: start, borrowin, a, d (requester -> subtractor);
//        p, borrowout, busy, done (subtractor -> requester).
interface serial_subtractor_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             borrowin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] p;
    logic             borrowout;
    logic             busy;
    logic             done;

    modport master (
        output start, borrowin, a, d,
        input  p, borrowout, busy, done
    );

    modport slave (
        input  start, borrowin, a, d,
        output p, borrowout, busy, done
    );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: p/borrowout = a - d - borrowin, one bit per clock, LSB first.
// Latency: start sampled at edge 0, done pulses in the cycle after edge WIDTH.
// Backpressure: start is ignored while busy; it is neither queued nor re-captured.
// Ports: clk, rst (sync, active-high), bus (slave side of serial_subtractor_8bit_if).
// Option: define SUB_SATURATE_EN to clamp p to 0 whenever the final borrow is set.
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_subtractor_8bit_if.slave      bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] d_sh;
    // Holds the difference bits produced so far, top-aligned; the bit
    // computed this cycle is appended above it to form the full result.
    logic [WIDTH-2:0] r_sh;
    logic             b_q;
    logic [WIDTH-1:0] p_q;
    logic             bo_q;

    logic             diff;
    logic             b_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] res_full;
    logic [WIDTH-1:0] res_load;

    // One full-subtractor slice on the current LSBs.
    always_comb begin
        diff     = a_sh[0] ^ d_sh[0] ^ b_q;
        b_nxt    = (~a_sh[0] & d_sh[0]) | (~(a_sh[0] ^ d_sh[0]) & b_q);
        last_bit = (cnt == LAST_BIT);
        res_full = {diff, r_sh};
`ifdef SUB_SATURATE_EN
        res_load = b_nxt ? '0 : res_full;
`else
        res_load = res_full;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            a_sh <= '0;
            d_sh <= '0;
            r_sh <= '0;
            b_q  <= 1'b0;
            p_q  <= '0;
            bo_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        d_sh <= bus.d;
                        b_q  <= bus.borrowin;
                        r_sh <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    d_sh <= d_sh >> 1;
                    r_sh <= res_full[WIDTH-1:1];
                    b_q  <= b_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        p_q  <= res_load;
                        bo_q <= b_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.p         = p_q;
    assign bus.borrowout = bo_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit against an arithmetic reference.
// Latency: checks done exactly one cycle after edge 8 relative to the start edge.
// Backpressure: drives random start/operands mid-operation and expects them ignored.
module tb_serial_subtractor_8bit;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_subtractor_8bit_if #(.WIDTH(8)) bif ();

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // {borrowout, p} from plain integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] a_i, input logic [7:0] d_i,
                                         input logic b_i);
        int diff;
        diff  = int'(a_i) - int'(d_i) - int'(b_i);
        model = 9'(diff);
`ifdef SUB_SATURATE_EN
        if (diff < 0) model = 9'h100;
`endif
    endfunction

    // Called positioned just after a negedge with the DUT idle. Drives start for
    // the next edge (edge 0), then scrambles start/operands while the op runs.
    task automatic do_op(input logic [7:0] a_i, input logic [7:0] d_i,
                         input logic b_i, input string tag);
        logic [8:0] exp;
        int         pulses;
        int         done_at;
        exp          = model(a_i, d_i, b_i);
        pulses       = 0;
        done_at      = -1;
        bif.start    = 1'b1;
        bif.a        = a_i;
        bif.d        = d_i;
        bif.borrowin = b_i;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(bif.busy), (k <= 8) ? 32'd1 : 32'd0);
            if (bif.done) begin
                pulses++;
                done_at = k;
                check({tag, "_p"}, 32'(bif.p), 32'(exp[7:0]));
                check({tag, "_bo"}, 32'(bif.borrowout), 32'(exp[8]));
            end
            if (k + 1 <= 9) begin
                bif.start    = 1'($urandom_range(0, 1));
                bif.a        = 8'($urandom);
                bif.d        = 8'($urandom);
                bif.borrowin = 1'($urandom_range(0, 1));
            end else begin
                bif.start = 1'b0;
            end
        end
        check({tag, "_done_at"}, 32'(done_at), 32'd8);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_p_hold"}, 32'(bif.p), 32'(exp[7:0]));
        check({tag, "_bo_hold"}, 32'(bif.borrowout), 32'(exp[8]));
    endtask

    initial begin
        logic [8:0] e1;
        logic [8:0] e2;
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bif.start    = 1'b1;
        bif.a        = 8'd7;
        bif.d        = 8'd3;
        bif.borrowin = 1'b0;

        // Reset wins over a simultaneous start.
        repeat (3) @(negedge clk);
        check("rst_p", 32'(bif.p), 32'd0);
        check("rst_bo", 32'(bif.borrowout), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);
        rst = 1'b0;

        // First start right after reset release.
        do_op(8'd60, 8'd50, 1'b0, "v60_50");
        do_op(8'd50, 8'd60, 1'b0, "v50_60");
        do_op(8'd75, 8'd23, 1'b1, "v75_23");
        do_op(8'd0, 8'd0, 1'b1, "wrap");
        do_op(8'd255, 8'd255, 1'b1, "ff_ff");
        do_op(8'd255, 8'd0, 1'b0, "ff_0");

        // Held start: a new op is captured only when the machine is back in IDLE.
        e1           = model(8'd45, 8'd34, 1'b0);
        e2           = model(8'd200, 8'd1, 1'b0);
        bif.start    = 1'b1;
        bif.a        = 8'd45;
        bif.d        = 8'd34;
        bif.borrowin = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("held_done", 32'(bif.done), (k == 8 || k == 18) ? 32'd1 : 32'd0);
            if (k == 8)  check("held_p1", 32'(bif.p), 32'(e1[7:0]));
            if (k == 18) check("held_p2", 32'(bif.p), 32'(e2[7:0]));
            if (k == 9)  check("held_idle", 32'(bif.busy), 32'd0);
            if (k == 10) check("held_restart", 32'(bif.busy), 32'd1);
            if (k == 2) begin
                bif.a = 8'd200;
                bif.d = 8'd1;
            end
            if (k >= 18) bif.start = 1'b0;
        end

        // Reset aborts an operation without a done pulse.
        bif.start    = 1'b1;
        bif.a        = 8'd90;
        bif.d        = 8'd17;
        bif.borrowin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_nodone", 32'(bif.done), 32'd0);
            bif.start = 1'b0;
            if (k == 3) rst = 1'b1;
        end
        @(negedge clk);
        check("abort_done", 32'(bif.done), 32'd0);
        check("abort_busy", 32'(bif.busy), 32'd0);
        check("abort_p", 32'(bif.p), 32'd0);
        check("abort_bo", 32'(bif.borrowout), 32'd0);
        rst = 1'b0;
        do_op(8'd34, 8'd45, 1'b0, "after_rst");

        // Random operands.
        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; WIDTH 8 is the only supported value.
REQ-002 The block SHALL have clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have start  input  1  request; sampled only in IDLE.
REQ-005 The block SHALL have borrowin  input  1  borrow into the LSB; captured with start.
REQ-006 The block SHALL have a  input  WIDTH  minuend; captured with start.
REQ-007 The block SHALL have d  input  WIDTH  subtrahend; captured with start.
REQ-008 The block SHALL have p  output  WIDTH  registered difference; holds until the next completion or reset.
REQ-009 The block SHALL have borrowout  output  1  registered borrow out of the MSB; updates with p.
REQ-010 The block SHALL have busy  output  1  high while in SHIFT or DONE.
REQ-011 The block SHALL have done  output  1  one-cycle pulse; p and borrowout are valid in the same cycle.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL capture a, d and borrowin into internal shift registers, clear the bit counter to 0 and move to SHIFT.
REQ-014 In SHIFT, each edge SHALL process one bit, LSB first: diff = a0^d0^b; b_next = (~a0&d0) | (~(a0^d0)&b).
REQ-015 In SHIFT, each edge SHALL shift the operand registers right by one, shift diff into the result MSB and increment the counter.
REQ-016 The edge that processes bit WIDTH-1 SHALL move the machine to DONE.
REQ-017 On that same edge, p SHALL load the completed result and borrowout SHALL load the final b.
REQ-018 In DONE, done SHALL be 1 and busy SHALL be 1; the next edge SHALL return the machine to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge 0, done SHALL be high exactly in the cycle after edge WIDTH (edge 8), and low in all other cycles.
REQ-020 Result: without saturation, {borrowout,p} SHALL equal (a - d - borrowin) in WIDTH+1-bit two's complement; borrowout=1 exactly when a < d+borrowin.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored; it SHALL not be queued and captured values SHALL not change.
REQ-022 start held high continuously SHALL begin a new operation on the first edge back in IDLE, giving one operation per WIDTH+2 cycles.
REQ-023 a, d and borrowin SHALL not affect an operation in progress after capture.
REQ-024 Wrap-around: 0 - 0 with borrowin=1 SHALL give p=8'hFF, borrowout=1.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, counter 0, p=0, borrowout=0, busy=0, done=0, and clear all shift registers.
REQ-026 Reset SHALL override every other input, including start on the same edge, and SHALL abort any operation in progress without a done pulse.
REQ-027 The first start is accepted at the first edge after rst deasserts.

Configuration
REQ-028 Macro SUB_SATURATE_EN defined: when the final borrow is 1, p SHALL load 0 (unsigned floor clamp) and borrowout SHALL still be 1.
REQ-029 Macro SUB_SATURATE_EN undefined: p SHALL be the modular difference per REQ-020; no other behaviour changes.

Verification
REQ-030 a=60, d=50, borrowin=0, start pulse -> done 8 edges later; p=10, borrowout=0.
REQ-031 a=50, d=60, borrowin=0 -> p=246, borrowout=1; with SUB_SATURATE_EN -> p=0, borrowout=1.
REQ-032 a=75, d=23, borrowin=1 -> p=51, borrowout=0; then a=0, d=0, borrowin=1 -> p=255, borrowout=1.
REQ-033 a=45, d=34 started; at edge 3 apply a=200, d=1, start=1 -> ignored; p=11, exactly one done pulse; start held high -> next op begins at the edge after DONE.
REQ-034 Op started, rst=1 at edge 4 -> no done pulse; p=0, borrowout=0, busy=0 next cycle; new op a=34, d=45 -> p=245, borrowout=1.
